// File: rtl/data_mem_arbiter_pkg.sv
// Shared definitions for the data memory arbiter: FSM states, default widths
// and requester port indices.
package data_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2
    } arb_state_t;

    localparam int ADDR_W_DEF  = 32;
    localparam int DATA_W_DEF  = 32;
    localparam int MEM_LAT_DEF = 1;

    localparam logic PORT_CORE = 1'b0;
    localparam logic PORT_DBG  = 1'b1;

    // The loser of an arbitration round is favoured in the next one.
    function automatic logic other_port(input logic port);
        return ~port;
    endfunction

endpackage

// File: rtl/data_mem_arbiter_rr.sv
// Two-way round-robin picker: one-hot grant from the request pair and the
// priority pointer, plus the pointer value to use after this grant.
module rr_arb2
    import data_mem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] gnt,
    output logic       next_ptr
);

    always_comb begin
        gnt      = 2'b00;
        next_ptr = ptr;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (ptr == PORT_DBG) ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
        if (gnt[0]) begin
            next_ptr = other_port(PORT_CORE);
        end else if (gnt[1]) begin
            next_ptr = other_port(PORT_DBG);
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares the single-port data memory between the core load/store unit (port 0)
// and the debug/loader (port 1), one access at a time, round-robin.
module data_mem_arbiter
    import data_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int MEM_LAT = MEM_LAT_DEF
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,

    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,

    output logic              mem_rd,
    output logic              mem_wr,
    output logic              mem_cs_n,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              busy
);

    localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    arb_state_t        state;
    logic              rr_ptr;
    logic              owner;
    logic              we_q;
    logic [LAT_W-1:0]  lat_cnt;

    logic [1:0]        req_vec;
    logic [1:0]        win_gnt;
    logic              next_ptr;

    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    assign req_vec = {m1_req, m0_req};

    rr_arb2 u_rr_arb2 (
        .req      (req_vec),
        .ptr      (rr_ptr),
        .gnt      (win_gnt),
        .next_ptr (next_ptr)
    );

    always_comb begin
        sel_we    = m0_we;
        sel_addr  = m0_addr;
        sel_wdata = m0_wdata;
        if (win_gnt[1]) begin
            sel_we    = m1_we;
            sel_addr  = m1_addr;
            sel_wdata = m1_wdata;
        end
    end

    // Every output is a register; memory strobes are set up on the grant edge
    // so they are valid for exactly the ACCESS cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= PORT_CORE;
            owner     <= PORT_CORE;
            we_q      <= 1'b0;
            lat_cnt   <= '0;
            m0_gnt    <= 1'b0;
            m1_gnt    <= 1'b0;
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_cs_n  <= 1'b1;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
        end else begin
            m0_gnt    <= 1'b0;
            m1_gnt    <= 1'b0;
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req_vec) begin
                        owner     <= win_gnt[1];
                        we_q      <= sel_we;
                        mem_addr  <= sel_addr;
                        mem_wdata <= sel_wdata;
                        mem_cs_n  <= 1'b0;
                        mem_rd    <= ~sel_we;
                        mem_wr    <= sel_we;
                        m0_gnt    <= win_gnt[0];
                        m1_gnt    <= win_gnt[1];
                        rr_ptr    <= next_ptr;
                        state     <= ACCESS;
                        busy      <= 1'b1;
                    end
                end
                ACCESS: begin
                    mem_cs_n <= 1'b1;
                    mem_rd   <= 1'b0;
                    mem_wr   <= 1'b0;
                    if (we_q) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state   <= WAIT;
                        lat_cnt <= LAT_W'(MEM_LAT - 1);
                    end
                end
                WAIT: begin
                    if (lat_cnt == '0) begin
                        if (owner == PORT_DBG) begin
                            m1_rdata  <= mem_rdata;
                            m1_rvalid <= 1'b1;
                        end else begin
                            m0_rdata  <= mem_rdata;
                            m0_rvalid <= 1'b1;
                        end
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    mem_cs_n <= 1'b1;
                    mem_rd   <= 1'b0;
                    mem_wr   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboard bench for data_mem_arbiter: a MEM_LAT=1 instance with a behavioural
// memory for most scenarios and a MEM_LAT=3 instance for the latency case.
module tb_data_mem_arbiter;
    import data_mem_arbiter_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #10 clk = ~clk;

    logic          m0_req, m0_we, m0_gnt, m0_rvalid;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata, m0_rdata;
    logic          m1_req, m1_we, m1_gnt, m1_rvalid;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata, m1_rdata;
    logic          mem_rd, mem_wr, mem_cs_n, busy;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;

    logic          c_req, c_we, c_gnt, c_rvalid, c_busy;
    logic [AW-1:0] c_addr;
    logic [DW-1:0] c_wdata, c_rdata;
    logic          c1_gnt, c1_rvalid;
    logic [DW-1:0] c1_rdata;
    logic          c_mem_rd, c_mem_wr, c_mem_cs_n;
    logic [AW-1:0] c_mem_addr;
    logic [DW-1:0] c_mem_wdata, c_mem_rdata;

    data_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1)) u_dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_cs_n(mem_cs_n), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    data_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .m0_req(c_req), .m0_we(c_we), .m0_addr(c_addr), .m0_wdata(c_wdata),
        .m0_gnt(c_gnt), .m0_rvalid(c_rvalid), .m0_rdata(c_rdata),
        .m1_req(1'b0), .m1_we(1'b0), .m1_addr('0), .m1_wdata('0),
        .m1_gnt(c1_gnt), .m1_rvalid(c1_rvalid), .m1_rdata(c1_rdata),
        .mem_rd(c_mem_rd), .mem_wr(c_mem_wr), .mem_cs_n(c_mem_cs_n), .mem_addr(c_mem_addr),
        .mem_wdata(c_mem_wdata), .mem_rdata(c_mem_rdata), .busy(c_busy)
    );

    // Behavioural data memories: one-cycle registered read, and a three-stage read pipe.
    logic [DW-1:0] mem_a [0:63];
    logic [DW-1:0] mem_c [0:63];
    logic [DW-1:0] pipe_c [0:2];

    always @(posedge clk) begin
        if (!mem_cs_n) begin
            if (mem_wr) mem_a[mem_addr[5:0]] <= mem_wdata;
            if (mem_rd) mem_rdata <= mem_a[mem_addr[5:0]];
        end
    end

    always @(posedge clk) begin
        pipe_c[1] <= pipe_c[0];
        pipe_c[2] <= pipe_c[1];
        if (!c_mem_cs_n) begin
            if (c_mem_wr) mem_c[c_mem_addr[5:0]] <= c_mem_wdata;
            if (c_mem_rd) pipe_c[0] <= mem_c[c_mem_addr[5:0]];
        end
    end
    assign c_mem_rdata = pipe_c[2];

    typedef struct {
        int            port;
        logic [DW-1:0] data;
        int            issue;
        bit            chk_lat;
        int            lat;
    } rd_exp_t;

    int      gnt_q[$];
    rd_exp_t rd_q[$];
    rd_exp_t rd3_q[$];
    int      total = 0;
    int      bad = 0;
    int      cyc = 0;
    int      cs_low_cnt = 0;
    int      gnt_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic reportUnexpected(input string name, input logic [63:0] act);
        total++;
        bad++;
        $display("[TB] FAIL %s: got 0x%0h, expected no event", name, act);
    endtask

    // Monitor for the MEM_LAT=1 instance: pops expectations as grants and read data appear.
    always @(negedge clk) begin
        if (!rst) begin
            if (m0_gnt || m1_gnt) begin
                gnt_cnt++;
                if (m0_gnt && m1_gnt) reportUnexpected("dual_gnt", 64'h3);
                else if (gnt_q.size() == 0) reportUnexpected("unexpected_gnt", 64'(m1_gnt));
                else checkOutput("gnt_port", 64'(m1_gnt), 64'(gnt_q.pop_front()));
            end
            if (m0_rvalid || m1_rvalid) begin
                if (m0_rvalid && m1_rvalid) begin
                    reportUnexpected("dual_rvalid", 64'h3);
                end else if (rd_q.size() == 0) begin
                    reportUnexpected("unexpected_rvalid", 64'(m1_rvalid));
                end else begin
                    rd_exp_t e;
                    e = rd_q.pop_front();
                    checkOutput("rvalid_port", 64'(m1_rvalid), 64'(e.port));
                    checkOutput("rdata", 64'(m1_rvalid ? m1_rdata : m0_rdata), 64'(e.data));
                    if (e.chk_lat) checkOutput("rd_latency", 64'(cyc - e.issue), 64'(e.lat));
                end
            end
            if (!mem_cs_n) begin
                cs_low_cnt++;
                checkOutput("rd_xor_wr", 64'(mem_rd ^ mem_wr), 64'h1);
            end else if (mem_rd || mem_wr) begin
                reportUnexpected("strobe_without_cs", 64'({mem_rd, mem_wr}));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && c_rvalid) begin
            if (rd3_q.size() == 0) begin
                reportUnexpected("unexpected_rvalid_lat3", 64'h1);
            end else begin
                rd_exp_t e;
                e = rd3_q.pop_front();
                checkOutput("rdata_lat3", 64'(c_rdata), 64'(e.data));
                checkOutput("rd_latency_lat3", 64'(cyc - e.issue), 64'(e.lat));
            end
        end
    end

    task automatic applyStimulus(input int port, input logic we, input logic [AW-1:0] addr,
                                 input logic [DW-1:0] wdata, input logic [DW-1:0] exp_rdata,
                                 input bit push_rd, input bit chk_lat, output int wait_cyc);
        logic g;
        @(posedge clk); #1;
        if (port == 0) begin
            m0_req = 1'b1; m0_we = we; m0_addr = addr; m0_wdata = wdata;
        end else begin
            m1_req = 1'b1; m1_we = we; m1_addr = addr; m1_wdata = wdata;
        end
        if (!we && push_rd) rd_q.push_back('{port, exp_rdata, cyc, chk_lat, 3});
        wait_cyc = 0;
        forever begin
            @(posedge clk); #1;
            wait_cyc++;
            g = (port == 0) ? m0_gnt : m1_gnt;
            if (g) break;
            if (wait_cyc > 30) begin
                reportUnexpected("gnt_timeout", 64'(port));
                break;
            end
        end
        if (port == 0) m0_req = 1'b0;
        else m1_req = 1'b0;
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        while ((busy || gnt_q.size() != 0 || rd_q.size() != 0) && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 30) reportUnexpected("idle_timeout", 64'(n));
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int w0, w1, n;
        bit seen;
        m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
        m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
        c_req = 0; c_we = 0; c_addr = '0; c_wdata = '0;
        for (int i = 0; i < 64; i++) begin
            mem_a[i] = '0;
            mem_c[i] = '0;
        end
        for (int i = 0; i < 3; i++) pipe_c[i] = '0;
        mem_c[12] = 32'hCAFE_0003;

        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_cs_n", 64'(mem_cs_n), 64'h1);
        checkOutput("rst_rd_wr", 64'({mem_rd, mem_wr}), 64'h0);
        checkOutput("rst_busy", 64'(busy), 64'h0);
        checkOutput("rst_addr", 64'(mem_addr), 64'h0);
        checkOutput("rst_gnt_rvalid", 64'({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid}), 64'h0);
        checkOutput("rst_rdata", 64'({m0_rdata, m1_rdata}), 64'h0);
        rst = 1'b0;

        $display("[TB] reset in the middle of a read access");
        @(posedge clk); #1;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'd3;
        @(posedge clk); #1;
        checkOutput("t1_gnt", 64'(m0_gnt), 64'h1);
        checkOutput("t1_access_cs_n", 64'(mem_cs_n), 64'h0);
        rst = 1'b1;
        m0_req = 1'b0;
        #1;
        checkOutput("t1_rst_cs_n", 64'(mem_cs_n), 64'h1);
        checkOutput("t1_rst_rd_wr", 64'({mem_rd, mem_wr}), 64'h0);
        checkOutput("t1_rst_busy", 64'(busy), 64'h0);
        repeat (2) begin
            @(posedge clk); #1;
            checkOutput("t1_rst_hold", 64'({busy, m0_rvalid, m1_rvalid, mem_cs_n}), 64'h1);
        end
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        $display("[TB] single port write then read");
        gnt_q.push_back(0);
        applyStimulus(0, 1'b1, 32'd10, 32'd20, '0, 1'b0, 1'b0, w0);
        checkOutput("t2_wr_gnt_wait", 64'(w0), 64'h1);
        waitIdle();
        gnt_q.push_back(0);
        applyStimulus(0, 1'b0, 32'd10, '0, 32'd20, 1'b1, 1'b1, w0);
        waitIdle();
        checkOutput("t2_m0_rdata_hold", 64'(m0_rdata), 64'd20);
        checkOutput("t2_m1_rdata_idle", 64'(m1_rdata), 64'h0);

        $display("[TB] simultaneous requests after reset");
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        gnt_q.push_back(0);
        gnt_q.push_back(1);
        fork
            applyStimulus(0, 1'b1, 32'd4, 32'hA5, '0, 1'b0, 1'b0, w0);
            applyStimulus(1, 1'b1, 32'd8, 32'h5A, '0, 1'b0, 1'b0, w1);
        join
        checkOutput("t3_m1_wait", 64'(w1), 64'h3);
        waitIdle();
        gnt_q.push_back(0);
        gnt_q.push_back(1);
        rd_q.push_back('{0, 32'hA5, 0, 1'b0, 0});
        rd_q.push_back('{1, 32'h5A, 0, 1'b0, 0});
        fork
            applyStimulus(0, 1'b0, 32'd4, '0, '0, 1'b0, 1'b0, w0);
            applyStimulus(1, 1'b0, 32'd8, '0, '0, 1'b0, 1'b0, w1);
        join
        waitIdle();

        $display("[TB] both ports hold requests for six accesses");
        for (int i = 0; i < 6; i++) gnt_q.push_back(i % 2);
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'd20; m0_wdata = 32'd1;
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'd21; m1_wdata = 32'd2;
        n = 0;
        for (int k = 0; k < 40 && n < 6; k++) begin
            @(posedge clk); #1;
            if (m0_gnt || m1_gnt) n++;
        end
        m0_req = 1'b0;
        m1_req = 1'b0;
        checkOutput("t4_grant_count", 64'(n), 64'd6);
        waitIdle();

        $display("[TB] lone port 1 request while port 0 holds priority");
        gnt_q.push_back(1);
        applyStimulus(1, 1'b0, 32'd8, '0, 32'h5A, 1'b1, 1'b1, w1);
        checkOutput("t5_m1_gnt_wait", 64'(w1), 64'h1);
        waitIdle();

        $display("[TB] read through the MEM_LAT=3 instance");
        @(posedge clk); #1;
        c_req = 1'b1; c_we = 1'b0; c_addr = 32'd12;
        rd3_q.push_back('{0, 32'hCAFE_0003, cyc, 1'b1, 5});
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(posedge clk); #1;
            if (c_gnt) c_req = 1'b0;
            if (c_rvalid) seen = 1'b1;
            else checkOutput("t6_busy", 64'(c_busy), 64'h1);
        end
        c_req = 1'b0;
        checkOutput("t6_rvalid_seen", 64'(seen), 64'h1);
        @(posedge clk); #1;
        checkOutput("t6_busy_after", 64'(c_busy), 64'h0);

        repeat (2) @(posedge clk);
        #1;
        checkOutput("cs_low_per_access", 64'(cs_low_cnt), 64'(gnt_cnt));
        checkOutput("gnt_q_drained", 64'(gnt_q.size()), 64'h0);
        checkOutput("rd_q_drained", 64'(rd_q.size()), 64'h0);
        checkOutput("rd3_q_drained", 64'(rd3_q.size()), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
